// File: rtl/cache_ctrl_if.sv
// CPU-side and memory-side signal bundle for cache_ctrl.
// The slave modport is the controller's view; master is the requester/memory side.
interface cache_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              flush;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic              cpu_done;
  logic [DATA_W-1:0] cpu_rdata;
  logic              hit;
  logic              miss;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [7:0]        hit_cnt;
  logic [7:0]        miss_cnt;

  // Handshakes: a CPU request transfers on an edge where cpu_req && cpu_ready;
  // mem_req is held with stable mem_addr/mem_we/mem_wdata until an edge with mem_ack.
  modport slave (
    input  flush, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    output cpu_ready, cpu_done, cpu_rdata, hit, miss,
           mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
  );

  modport master (
    output flush, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    input  cpu_ready, cpu_done, cpu_rdata, hit, miss,
           mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with one
// word per line, single-cycle flush and saturating hit/miss counters.
module cache_ctrl #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 8,
  parameter int INDEX_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  cache_ctrl_if.slave bus,
  output logic [1:0]  dbg_state
);
  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, FILL, WRITE} state_t;

  state_t              state, state_nxt;
  logic                req_we;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [LINES-1:0]    valid;
  logic [TAG_W-1:0]    tag_arr  [LINES];
  logic [DATA_W-1:0]   data_arr [LINES];

  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    req_tag;
  logic                lookup_hit;

  logic                accept, flush_en, fill_en, arr_we;
  logic [DATA_W-1:0]   arr_wdata;
  logic                done_nxt, hit_nxt, miss_nxt, mreq_nxt, mwe_nxt;
  logic [ADDR_W-1:0]   maddr_nxt;
  logic [DATA_W-1:0]   mwdata_nxt, rdata_nxt;

  assign idx           = req_addr[INDEX_W-1:0];
  assign req_tag       = req_addr[ADDR_W-1:INDEX_W];
  assign lookup_hit    = valid[idx] && (tag_arr[idx] == req_tag);
  assign bus.cpu_ready = (state == IDLE) && !bus.flush;
  assign dbg_state     = state;

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    flush_en   = 1'b0;
    fill_en    = 1'b0;
    arr_we     = 1'b0;
    arr_wdata  = req_wdata;
    done_nxt   = 1'b0;
    hit_nxt    = 1'b0;
    miss_nxt   = 1'b0;
    mreq_nxt   = bus.mem_req;
    mwe_nxt    = bus.mem_we;
    maddr_nxt  = bus.mem_addr;
    mwdata_nxt = bus.mem_wdata;
    rdata_nxt  = bus.cpu_rdata;
    unique case (state)
      IDLE: begin
        if (bus.flush) begin
          flush_en = 1'b1;
        end else if (bus.cpu_req) begin
          accept    = 1'b1;
          state_nxt = LOOKUP;
        end
      end
      LOOKUP: begin
        hit_nxt  = lookup_hit;
        miss_nxt = !lookup_hit;
        if (!req_we && lookup_hit) begin
          rdata_nxt = data_arr[idx];
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (!req_we) begin
          mreq_nxt  = 1'b1;
          mwe_nxt   = 1'b0;
          maddr_nxt = req_addr;
          state_nxt = FILL;
        end else begin
          // Write-through: memory is always written; the line is updated only on a hit.
          arr_we     = lookup_hit;
          mreq_nxt   = 1'b1;
          mwe_nxt    = 1'b1;
          maddr_nxt  = req_addr;
          mwdata_nxt = req_wdata;
          state_nxt  = WRITE;
        end
      end
      FILL: begin
        if (bus.mem_ack) begin
          arr_we    = 1'b1;
          arr_wdata = bus.mem_rdata;
          fill_en   = 1'b1;
          rdata_nxt = bus.mem_rdata;
          done_nxt  = 1'b1;
          mreq_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      WRITE: begin
        if (bus.mem_ack) begin
          done_nxt  = 1'b1;
          mreq_nxt  = 1'b0;
          mwe_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      req_we        <= 1'b0;
      req_addr      <= '0;
      req_wdata     <= '0;
      valid         <= '0;
      bus.cpu_done  <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.hit       <= 1'b0;
      bus.miss      <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.hit_cnt   <= '0;
      bus.miss_cnt  <= '0;
    end else begin
      state         <= state_nxt;
      bus.cpu_done  <= done_nxt;
      bus.cpu_rdata <= rdata_nxt;
      bus.hit       <= hit_nxt;
      bus.miss      <= miss_nxt;
      bus.mem_req   <= mreq_nxt;
      bus.mem_we    <= mwe_nxt;
      bus.mem_addr  <= maddr_nxt;
      bus.mem_wdata <= mwdata_nxt;
      if (accept) begin
        req_we    <= bus.cpu_we;
        req_addr  <= bus.cpu_addr;
        req_wdata <= bus.cpu_wdata;
      end
      if (flush_en) begin
        valid <= '0;
      end else if (fill_en) begin
        valid[idx] <= 1'b1;
      end
      if (hit_nxt && bus.hit_cnt != 8'hFF) begin
        bus.hit_cnt <= bus.hit_cnt + 8'd1;
      end
      if (miss_nxt && bus.miss_cnt != 8'hFF) begin
        bus.miss_cnt <= bus.miss_cnt + 8'd1;
      end
    end
  end

  // Tag and data storage carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      data_arr[idx] <= arr_wdata;
    end
    if (fill_en) begin
      tag_arr[idx] <= req_tag;
    end
  end
endmodule
